// File: rtl/spi_tx_queue.sv
// spi_tx_queue: host-side byte FIFO feeding the SPI controller.
// Each entry holds a byte and a "last" flag. The FSM frames entries into
// chip-select-delimited transactions and hands bytes to the controller
// over the o_tx_dv / i_tx_ready handshake.
// Optional status ports (o_level, o_overflow, i_clr_overflow) are built
// when SPI_TX_QUEUE_STATUS_EN is defined.
module spi_tx_queue #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned CS_SETUP_CLKS = 2,
  parameter int unsigned CS_HOLD_CLKS  = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_en,
  input  logic [7:0]          i_wr_byte,
  input  logic                i_wr_last,
  output logic                o_full,
  output logic                o_empty,
  output logic [7:0]          o_tx_byte,
  output logic                o_tx_dv,
  input  logic                i_tx_ready,
  output logic                o_spi_cs_n,
  output logic                o_busy
`ifdef SPI_TX_QUEUE_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0] o_level,
  output logic                o_overflow,
  input  logic                i_clr_overflow
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Phase counter terminal values; only consulted when the matching
  // parameter is non-zero.
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CLKS - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD_CLKS - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] NEXT  = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] XFER  = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;

  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nx;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [8:0]            head;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [15:0]           cnt;
  logic                  seen_low;
  logic                  last_q;

  // o_full is the registered pre-pop flag, so a pop never makes room for
  // a write landing in the same cycle.
  assign wr_ok = i_wr_en && !o_full;
  assign rd_ok = (state == ISSUE);
  assign head  = mem[rd_ptr];

  // Next FIFO occupancy from this cycle's write/pop pair.
  always_comb begin
    count_nx = count;
    if (wr_ok && !rd_ok) begin
      count_nx = count + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_nx = count - CNT_ONE;
    end
  end

  // Storage array; not reset, pointers alone define the valid contents.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {i_wr_last, i_wr_byte};
    end
  end

  // FIFO pointers, occupancy and registered full/empty flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_full  <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count   <= count_nx;
      o_full  <= (count_nx == FULL_CNT);
      o_empty <= (count_nx == '0);
    end
  end

  // Transaction sequencing: CS setup, per-byte handshake, CS hold.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!o_empty) begin
          state_nx = (CS_SETUP_CLKS == 0) ? NEXT : SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nx = NEXT;
        end
      end
      NEXT: begin
        if (!o_empty && i_tx_ready) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        state_nx = XFER;
      end
      XFER: begin
        // Ready must have dropped once after the pulse so the controller's
        // pre-pulse ready is not mistaken for completion.
        if (seen_low && i_tx_ready) begin
          if (last_q) begin
            state_nx = (CS_HOLD_CLKS == 0) ? IDLE : HOLD;
          end else begin
            state_nx = NEXT;
          end
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register plus outputs registered from the upcoming state, so
  // cs_n/busy/dv line up exactly with the state they describe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      seen_low   <= 1'b0;
      last_q     <= 1'b0;
      o_tx_byte  <= '0;
      o_tx_dv    <= 1'b0;
      o_spi_cs_n <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nx;
      o_spi_cs_n <= (state_nx == IDLE);
      o_busy     <= (state_nx != IDLE);
      o_tx_dv    <= (state_nx == ISSUE);
      if (state_nx == ISSUE) begin
        o_tx_byte <= head[7:0];
      end

      if (state_nx != state) begin
        cnt <= '0;
      end else if (state == SETUP || state == HOLD) begin
        cnt <= cnt + 16'd1;
      end

      if (state == ISSUE) begin
        last_q   <= head[8];
        seen_low <= 1'b0;
      end else if (state == XFER && !i_tx_ready) begin
        seen_low <= 1'b1;
      end
    end
  end

`ifdef SPI_TX_QUEUE_STATUS_EN
  // Registered occupancy and sticky overflow; a new overflow beats a clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_level    <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_level <= count_nx;
      if (i_wr_en && o_full) begin
        o_overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        o_overflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: scoreboard of queued bytes checked against each
// dv pulse, plus per-scenario framing checks. Build with
// SPI_TX_QUEUE_STATUS_EN defined to also cover the status ports.
module tb_spi_tx_queue;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       wr_en    = 1'b0;
  logic [7:0] wr_byte  = '0;
  logic       wr_last  = 1'b0;
  logic       tx_ready = 1'b0;
  logic       full, empty, tx_dv, cs_n, busy;
  logic [7:0] tx_byte;
`ifdef SPI_TX_QUEUE_STATUS_EN
  logic [DL2:0] level;
  logic         overflow;
  logic         clr_ov = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         wr_acc = 0;
  int         dv_total = 0;
  int         dv_base = 0;
  bit         stall = 1'b0;
  int         ctrl_cnt = 0;
  bit         prev_dv = 1'b0;

  always #5 clk = ~clk;

  spi_tx_queue #(
    .DEPTH_LOG2   (DL2),
    .CS_SETUP_CLKS(SETUP),
    .CS_HOLD_CLKS (HOLD)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wr_en   (wr_en),
    .i_wr_byte (wr_byte),
    .i_wr_last (wr_last),
    .o_full    (full),
    .o_empty   (empty),
    .o_tx_byte (tx_byte),
    .o_tx_dv   (tx_dv),
    .i_tx_ready(tx_ready),
    .o_spi_cs_n(cs_n),
    .o_busy    (busy)
`ifdef SPI_TX_QUEUE_STATUS_EN
    ,
    .o_level       (level),
    .o_overflow    (overflow),
    .i_clr_overflow(clr_ov)
`endif
  );

  // Controller model: ready drops the cycle after dv and stays low 8 cycles.
  always @(negedge clk) begin
    if (rst) ctrl_cnt = 0;
    else if (tx_dv) ctrl_cnt = 8;
    else if (ctrl_cnt > 0) ctrl_cnt--;
    tx_ready = (ctrl_cnt == 0) && !stall;
  end

  // Scoreboard monitor: every dv pulse must match the oldest queued byte.
  always @(negedge clk) begin
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (tx_dv) begin
        dv_total++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dv_unexpected: got pulse with byte %02h, expected no pulse", tx_byte);
        end else begin
          exp_b = sb.pop_front();
          if (tx_byte !== exp_b) begin
            errors++;
            $display("FAIL tx_byte: got %02h, expected %02h", tx_byte, exp_b);
          end
        end
        checks++;
        if (prev_dv) begin
          errors++;
          $display("FAIL dv_double: got dv on consecutive cycles, expected single pulse");
        end
        checks++;
        if (cs_n !== 1'b0) begin
          errors++;
          $display("FAIL cs_during_dv: got cs_n=%b, expected 0", cs_n);
        end
      end
      prev_dv = tx_dv;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    wr_en = 1'b0;
    stall = 1'b0;
`ifdef SPI_TX_QUEUE_STATUS_EN
    clr_ov = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    sb.delete();
    wr_acc  = 0;
    dv_base = dv_total;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called on a negedge; returns on the following negedge.
  task automatic write_byte(input logic [7:0] b, input logic l);
    if (wr_acc - (dv_total - dv_base) < DEPTH) begin
      sb.push_back(b);
      wr_acc++;
    end
    wr_en = 1'b1; wr_byte = b; wr_last = l;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && empty) begin to = 1'b0; break; end
    end
  endtask

  // Observe one CS-low window: cycles before first dv, dv count, and
  // cycles CS stays low after ready returns following the last dv.
  task automatic observe_txn(output int su, output int ho, output int n, output bit to);
    bit started = 1'b0;
    bit got_dv = 1'b0;
    su = 0; ho = 0; n = 0; to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (!started && !cs_n) started = 1'b1;
      if (started) begin
        if (cs_n) begin to = 1'b0; break; end
        if (tx_dv) begin n++; got_dv = 1'b1; ho = 0; end
        else if (!got_dv) su++;
        else if (tx_ready) ho++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b, expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b, expected 0", full); end
    checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b, expected 0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %02h, expected 00", tx_byte); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b, expected 1", cs_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
`ifdef SPI_TX_QUEUE_STATUS_EN
    checks++; if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d, expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
`endif
  endtask

  task automatic test_basic();
    int su, ho, n;
    bit to;
    do_reset();
    fork
      begin write_byte(8'hA5, 1'b0); write_byte(8'h3C, 1'b1); end
      observe_txn(su, ho, n, to);
    join
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no CS release, expected release"); end
    checks++; if (su < SETUP || su > SETUP + 1) begin errors++; $display("FAIL basic_setup: got %0d cycles, expected %0d..%0d", su, SETUP, SETUP + 1); end
    checks++; if (ho < HOLD || ho > HOLD + 1) begin errors++; $display("FAIL basic_hold: got %0d cycles, expected %0d..%0d", ho, HOLD, HOLD + 1); end
    checks++; if (n != 2) begin errors++; $display("FAIL basic_dv_count: got %0d, expected 2", n); end
    @(negedge clk);
    checks++; if (cs_n !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL basic_end: got cs_n=%b busy=%b empty=%b, expected 1 0 1", cs_n, busy, empty); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_sb: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_overflow();
    bit to;
    do_reset();
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'h40 + 8'(i), (i >= 15));
      if (i == 14) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full15: got %b, expected 0", full); end
      end
      if (i == 15) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full16: got %b, expected 1", full); end
`ifdef SPI_TX_QUEUE_STATUS_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, expected 0", overflow); end
`endif
      end
    end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL ovf_full17: got full=%b empty=%b, expected 1 0", full, empty); end
`ifdef SPI_TX_QUEUE_STATUS_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d, expected 16", level); end
    clr_ov = 1'b1;
    @(negedge clk);
    clr_ov = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
`endif
    stall = 1'b0;
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL ovf_drain_timeout: got busy, expected idle"); end
    checks++; if (dv_total - dv_base != 16) begin errors++; $display("FAIL ovf_dv_count: got %0d, expected 16", dv_total - dv_base); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovf_sb: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_underrun();
    bit to;
    do_reset();
    write_byte(8'h11, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (dv_total - dv_base != 1) begin errors++; $display("FAIL urun_dv1: got %0d, expected 1", dv_total - dv_base); end
    checks++; if (cs_n !== 1'b0 || busy !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL urun_hold_cs: got cs_n=%b busy=%b empty=%b, expected 0 1 1", cs_n, busy, empty); end
    write_byte(8'h22, 1'b1);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("FAIL urun_timeout: got busy, expected idle"); end
    checks++; if (cs_n !== 1'b1 || dv_total - dv_base != 2) begin errors++; $display("FAIL urun_end: got cs_n=%b dv=%0d, expected 1 2", cs_n, dv_total - dv_base); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL urun_sb: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_simultaneous();
    bit to;
    bit found = 1'b0;
    do_reset();
    write_byte(8'h31, 1'b0);
    write_byte(8'h32, 1'b0);
    for (int k = 0; k < 50; k++) begin
      if (tx_dv) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL simul_no_dv: got no pulse, expected pulse"); end
    write_byte(8'h33, 1'b1);
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL simul_flags: got empty=%b full=%b, expected 0 0", empty, full); end
`ifdef SPI_TX_QUEUE_STATUS_EN
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL simul_level: got %0d, expected 2", level); end
`endif
    wait_idle(to);
    checks++; if (to || dv_total - dv_base != 3) begin errors++; $display("FAIL simul_end: got timeout=%b dv=%0d, expected 0 3", to, dv_total - dv_base); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL simul_sb: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int falls = 0;
    int gap = 0;
    int min_gap = 1000;
    bit rose = 1'b0;
    bit done = 1'b0;
    logic prev_cs = 1'b1;
    do_reset();
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    for (int k = 0; k < 300 && !done; k++) begin
      if (prev_cs && !cs_n) begin
        falls++;
        if (rose && gap < min_gap) min_gap = gap;
      end
      if (!prev_cs && cs_n) begin rose = 1'b1; gap = 0; end
      if (cs_n && rose) gap++;
      if (falls == 2 && cs_n && !busy && empty) done = 1'b1;
      prev_cs = cs_n;
      @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout: got falls=%0d, expected completion", falls); end
    checks++; if (falls != 2) begin errors++; $display("FAIL b2b_falls: got %0d, expected 2", falls); end
    checks++; if (min_gap < 1) begin errors++; $display("FAIL b2b_gap: got %0d cycles, expected >=1", min_gap); end
    checks++; if (dv_total - dv_base != 2 || sb.size() != 0) begin errors++; $display("FAIL b2b_dv: got %0d pulses %0d pending, expected 2 0", dv_total - dv_base, sb.size()); end
  endtask

  task automatic test_reset_xfer();
    bit to;
    bit found = 1'b0;
    do_reset();
    write_byte(8'h55, 1'b0);
    write_byte(8'h66, 1'b1);
    for (int k = 0; k < 50; k++) begin
      if (tx_dv) begin found = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (!found || empty !== 1'b0) begin errors++; $display("FAIL rx_setup: got dv=%b empty=%b, expected 1 0", found, empty); end
    #2 rst = 1'b1;
    #1;
    checks++; if (cs_n !== 1'b1 || tx_dv !== 1'b0) begin errors++; $display("FAIL rx_async: got cs_n=%b dv=%b, expected 1 0", cs_n, tx_dv); end
    checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rx_flush: got empty=%b busy=%b, expected 1 0", empty, busy); end
    @(negedge clk);
    sb.delete();
    wr_acc  = 0;
    dv_base = dv_total;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (dv_total - dv_base != 0 || cs_n !== 1'b1) begin errors++; $display("FAIL rx_quiet: got dv=%0d cs_n=%b, expected 0 1", dv_total - dv_base, cs_n); end
    write_byte(8'h77, 1'b1);
    wait_idle(to);
    checks++; if (to || dv_total - dv_base != 1 || sb.size() != 0) begin errors++; $display("FAIL rx_after: got timeout=%b dv=%0d pending=%0d, expected 0 1 0", to, dv_total - dv_base, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underrun();
    test_simultaneous();
    test_back_to_back();
    test_reset_xfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
